// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of a single-port data memory.
// A requester owns the memory after one IDLE arbitration cycle; a locked owner
// keeps it for up to MAXBURST beats while the other side waits. An unchallenged
// owner keeps it for as many beats as it likes.
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   reqN/lockN/weN           requester N request, burst lock, write(1)/read(0)
//   addrN/wdataN             requester N word address and write data
//   gntN                     beat accepted for requester N (combinational)
//   rvalidN/rdataN           registered read response for requester N
//   mem_we/addr/wdata        shared memory command (combinational)
//   mem_rdata                combinational read data from memory at mem_addr
//   owner                    00 idle, 01 requester 0, 10 requester 1
module dmem_arbiter #(
  parameter int unsigned AW       = 4,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAXBURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;     // 1: requester 1 was served last
  logic          rvalid0_q, rvalid1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  logic          own_req, own_lock, oth_req, own_id;
  logic [CW:0]   cnt_inc;
  logic          burst_ok;

  // Grants and the memory command follow the current owner combinationally.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      OWN0: begin
        gnt0      = req0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
      end
      OWN1: begin
        gnt1      = req1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
      end
      default: ;
    endcase
    mem_we = (gnt0 & we0) | (gnt1 & we1);
  end

  // Owner-relative view so both OWN states share one decision tree.
  always_comb begin
    own_id   = (state_q == OWN1);
    own_req  = own_id ? req1  : req0;
    own_lock = own_id ? lock1 : lock0;
    oth_req  = own_id ? req0  : req1;
    cnt_inc  = {1'b0, cnt_q} + (CW+1)'(1);
    burst_ok = cnt_inc < (CW+1)'(MAXBURST);
  end

  // Next-state, beat counter and fairness bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0 && req1) state_d = last_q ? OWN0 : OWN1;
        else if (req0)    state_d = OWN0;
        else if (req1)    state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (own_req && own_lock && burst_ok) begin
          cnt_d = cnt_inc[CW-1:0];
        end else if (oth_req) begin
          state_d = own_id ? OWN0 : OWN1;
          cnt_d   = '0;
          last_d  = own_id;
        end else if (own_req) begin
          // Nobody waiting: keep ownership and restart the burst count.
          cnt_d = '0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          last_d  = own_id;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // All state plus registered read responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
      if (gnt0 && !we0) rdata0_q <= mem_rdata;
      if (gnt1 && !we1) rdata1_q <= mem_rdata;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign owner   = state_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: AW, 4, data-memory address width.
REQ-002 Parameter SHALL be: DW, 16, data width.
REQ-003 Parameter SHALL be: MAXBURST, 4, maximum consecutive locked beats per owner, range 1..15.
REQ-004 Ports SHALL be: clk  input  1  clock, rising-edge.
REQ-005 Ports SHALL be: rst  input  1  reset, asynchronous, active-low.
REQ-006 Ports SHALL be: reqN  input  1  requester N (N=0,1) access request, held until granted.
REQ-007 Ports SHALL be: lockN  input  1  requester N asks to keep ownership for a burst.
REQ-008 Ports SHALL be: weN  input  1  requester N write (1) / read (0).
REQ-009 Ports SHALL be: addrN  input  AW  requester N word address.
REQ-010 Ports SHALL be: wdataN  input  DW  requester N write data.
REQ-011 Ports SHALL be: gntN  output  1  beat accepted for requester N this cycle.
REQ-012 Ports SHALL be: rvalidN  output  1  read data valid for requester N.
REQ-013 Ports SHALL be: rdataN  output  DW  read data to requester N.
REQ-014 Ports SHALL be: mem_we, mem_addr, mem_wdata  output  1/AW/DW  shared data-memory write enable, address, write data.
REQ-015 Ports SHALL be: mem_rdata  input  DW  combinational read data from shared memory at mem_addr.
REQ-016 Ports SHALL be: owner  output  2  00 idle, 01 requester 0, 10 requester 1.

Function
REQ-017 FSM states SHALL be IDLE, OWN0, OWN1; owner output SHALL decode the state directly.
REQ-018 In IDLE no grant SHALL issue; with any req high the next state SHALL be OWN0/OWN1 (one arbitration cycle).
REQ-019 In IDLE with req0 and req1 both high, the requester not served last SHALL win; last_served SHALL reset to 1 so requester 0 wins first.
REQ-020 In OWNx, gntx SHALL equal reqx combinationally; the other gnt SHALL be 0.
REQ-021 mem_addr/mem_wdata SHALL follow the owner's addr/wdata in OWNx and hold 0 in IDLE; mem_we SHALL equal gntx & wex.
REQ-022 A granted read SHALL assert rvalidx for exactly one cycle on the following cycle with rdatax = mem_rdata captured at the grant edge; rdatax SHALL hold until the next read for that requester.
REQ-023 A 4-bit beat counter SHALL count granted beats in the current ownership, clearing on every state change.
REQ-024 From OWNx, if reqx & lockx and count+1 < MAXBURST, state SHALL stay OWNx.
REQ-025 Otherwise, if the other requester's req is high, state SHALL move to OWN(other) with no idle cycle; last_served SHALL become x.
REQ-026 Otherwise, if reqx is high, state SHALL stay OWNx and the counter SHALL clear (no competition, unlimited beats).
REQ-027 Otherwise state SHALL return to IDLE.
REQ-028 Requester address/data change while reqx is low SHALL have no effect on memory.
REQ-029 Write and read to the same address in consecutive beats SHALL return the new value (write completes at grant edge).

Reset
REQ-030 While rst is low: state IDLE, counter 0, last_served 1, gnt0/1 0, rvalid0/1 0, rdata0/1 0, mem_we 0, mem_addr 0, mem_wdata 0, owner 00.
REQ-031 rst asserted mid-burst SHALL abort immediately; a pending rvalid SHALL NOT be issued; no memory write SHALL occur while rst is low.
REQ-032 After rst deasserts, the first grant SHALL occur no earlier than the second rising edge (IDLE arbitration cycle).

Verification
REQ-033 Reset, req0 write addr 3 data 16'hBEEF then read addr 3 -> gnt0 one cycle after req0, rvalid0 next cycle with rdata0 = 16'hBEEF, owner 01.
REQ-034 req0 and req1 high in same cycle after reset, lock low, each 2 reads -> grants alternate 0,1,0,1 with no idle cycle between owners.
REQ-035 req0 locked, req1 waiting, MAXBURST=4 -> exactly 4 gnt0 beats, then OWN1 next cycle; req1 waits at most 4 beats.
REQ-036 Only req1 high with lock low for 10 cycles -> gnt1 every cycle after the first arbitration cycle, never returns to IDLE.
REQ-037 rst pulled low during OWN1 write burst -> mem_we 0 immediately, all outputs 0, owner 00; memory contents from earlier beats remain as written.
REQ-038 Read granted, then requester drops req -> rvalid still asserted one cycle later, state IDLE the cycle after last grant.
